// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS general-purpose register file: two combinational read ports,
// one synchronous write port, a registered debug read port and a saturating write counter.
module mips_register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [7:0]        wr_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              commit;

  // A write commits only when it is not swallowed by reset or aimed at $0.
  assign commit = wr_en && (wr_addr != '0) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[ADDR_W'(i)] <= '0;
      end
      dbg_data <= '0;
      wr_count <= '0;
    end else begin
      if (commit) begin
        regs[wr_addr] <= wr_data;
      end
      dbg_data <= (dbg_addr == '0) ? '0 : regs[dbg_addr];
      if (commit && (wr_count != 8'hFF)) begin
        wr_count <= wr_count + 8'd1;
      end
    end
  end

  always_comb begin
    rd_data1 = regs[rd_addr1];
    if (rd_addr1 == '0) begin
      rd_data1 = '0;
    end else if ((BYPASS != 0) && commit && (rd_addr1 == wr_addr)) begin
      rd_data1 = wr_data;
    end

    rd_data2 = regs[rd_addr2];
    if (rd_addr2 == '0) begin
      rd_data2 = '0;
    end else if ((BYPASS != 0) && commit && (rd_addr2 == wr_addr)) begin
      rd_data2 = wr_data;
    end
  end

endmodule

// File: tb/tb_mips_register_file.sv
// Scoreboard bench for mips_register_file: a write-through and a no-bypass instance
// share stimulus; a monitor compares every cycle against an array-based register model.
module tb_mips_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr, dbg_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] rd1_b, rd2_b, dbg_b, rd1_o, rd2_o, dbg_o;
  logic [7:0]  cnt_b, cnt_o;

  always #5 clk = ~clk;

  mips_register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_byp (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd1_b), .rd_data2(rd2_b), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg_b), .wr_count(cnt_b)
  );

  mips_register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_old (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd1_o), .rd_data2(rd2_o), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg_o), .wr_count(cnt_o)
  );

  typedef struct {
    logic [31:0] e1_byp, e2_byp, e1_old, e2_old, edbg;
    logic [7:0]  ecnt;
    bit          chk_rd, chk_st;
    string       tag;
  } item_t;

  item_t       sbq[$];
  int          total = 0;
  int          bad = 0;

  // Reference model: plain array of register values, write counter, debug register.
  logic [31:0] m [32];
  logic [31:0] m_dbg;
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: inputs settle after posedge; combinational reads are sampled at negedge.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        it = sbq.pop_front();
        if (it.chk_rd) begin
          check({it.tag, " rd1 byp"}, rd1_b, it.e1_byp);
          check({it.tag, " rd2 byp"}, rd2_b, it.e2_byp);
          check({it.tag, " rd1 old"}, rd1_o, it.e1_old);
          check({it.tag, " rd2 old"}, rd2_o, it.e2_old);
        end
        if (it.chk_st) begin
          check({it.tag, " dbg byp"}, dbg_b, it.edbg);
          check({it.tag, " dbg old"}, dbg_o, it.edbg);
          check({it.tag, " cnt byp"}, {24'd0, cnt_b}, {24'd0, it.ecnt});
          check({it.tag, " cnt old"}, {24'd0, cnt_o}, {24'd0, it.ecnt});
        end
      end
    end
  end

  function automatic logic [31:0] model_rd(input logic [4:0] a, input bit byp,
                                           input bit commit, input logic [4:0] wa,
                                           input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (byp && commit && a == wa) return wd;
    return m[a];
  endfunction

  // One clock cycle: drive inputs, push the expected observation, advance the model.
  task automatic cyc(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] da,
                     input bit chk_rd, input bit chk_st, input string tag);
    item_t it;
    bit commit;
    reset = r; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr1 = a1; rd_addr2 = a2; dbg_addr = da;
    commit = we && (wa != 5'd0) && !r;
    it.e1_byp = model_rd(a1, 1'b1, commit, wa, wd);
    it.e2_byp = model_rd(a2, 1'b1, commit, wa, wd);
    it.e1_old = model_rd(a1, 1'b0, commit, wa, wd);
    it.e2_old = model_rd(a2, 1'b0, commit, wa, wd);
    it.edbg = m_dbg;
    it.ecnt = 8'(m_cnt);
    it.chk_rd = chk_rd;
    it.chk_st = chk_st;
    it.tag = tag;
    sbq.push_back(it);
    if (r) begin
      for (int i = 0; i < 32; i++) m[i] = 32'd0;
      m_dbg = 32'd0;
      m_cnt = 0;
    end else begin
      m_dbg = (da == 5'd0) ? 32'd0 : m[da];
      if (commit) begin
        m[wa] = wd;
        if (m_cnt < 255) m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int writes;
    logic [4:0] wa, a1, a2, da;
    bit we;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr1 = '0; rd_addr2 = '0; dbg_addr = '0;
    for (int i = 0; i < 32; i++) m[i] = 32'hx;
    m_dbg = 32'hx;
    m_cnt = 0;
    @(posedge clk);
    #1;

    // Reset, then sweep every address with writes disabled and X data.
    cyc(1'b1, 1'b1, 5'd3, 32'h12345678, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, "reset");
    for (int a = 0; a < 32; a++) begin
      cyc(1'b0, 1'b0, 5'($urandom), 32'hx, 5'(a), 5'(31 - a), 5'(a), 1'b1, 1'b1, "sweep");
    end

    // Basic write / read.
    cyc(1'b0, 1'b1, 5'd8,  32'hDEADBEEF, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, "wr8");
    cyc(1'b0, 1'b1, 5'd31, 32'h00000001, 5'd8, 5'd0, 5'd8, 1'b1, 1'b1, "wr31");
    cyc(1'b0, 1'b0, 5'd0,  32'h0,        5'd8, 5'd31, 5'd31, 1'b1, 1'b1, "rd8_31");

    // $0 hardwire.
    cyc(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, "wr0");
    cyc(1'b0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd0, 1'b1, 1'b1, "rd0");

    // Read-during-write on r5 with debug read of r5 in the same cycle.
    cyc(1'b0, 1'b1, 5'd5, 32'h11111111, 5'd0, 5'd5, 5'd0, 1'b1, 1'b1, "wr5a");
    cyc(1'b0, 1'b1, 5'd5, 32'h22222222, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, "rdw5");
    cyc(1'b0, 1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 5'd0, 1'b1, 1'b1, "post5");

    // Reset colliding with a write to r9.
    cyc(1'b0, 1'b1, 5'd9, 32'h01010101, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, "wr9");
    cyc(1'b1, 1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, "rst_wr9");
    cyc(1'b0, 1'b0, 5'd0, 32'h0,        5'd9, 5'd5, 5'd9, 1'b1, 1'b1, "post_rst");

    // Random writes with wr_en toggling, running the counter into saturation.
    writes = 0;
    while (writes < 300) begin
      we = ($urandom_range(3) != 0);
      wa = ($urandom_range(15) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
      a1 = ($urandom_range(3) == 0) ? wa : 5'($urandom);
      a2 = 5'($urandom);
      da = 5'($urandom);
      if (we && wa != 5'd0) writes++;
      cyc(1'b0, we, wa, $urandom, a1, a2, da, 1'b1, 1'b1, "rand");
    end
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'($urandom), 5'($urandom), 5'd0, 1'b1, 1'b1, "sat");
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, "final");

    @(negedge clk);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    total++;
    if (m_cnt != 255) begin
      bad++;
      $display("FAIL model_sat: got %0d expected 255", m_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
